// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input combination onto a small combinational
// gate, waits a settle period, samples its output and compares it against a
// parameterised truth table. Reports pass/fail, mismatch count and the first
// failing vector.
module gate_truth_checker #(
  parameter int                       N_IN   = 2,
  parameter logic [(1 << N_IN)-1:0]   EXPECT = 4'b0111,
  parameter int                       SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            gate_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int            NUM_VEC     = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NUM_VEC - 1);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  state_t     state, state_next;
  logic [3:0] settle_cnt;
  logic       fail_flag;
  logic       mismatch;

  // The gate output is only acted upon in SAMPLE, so glitches elsewhere are harmless.
  assign mismatch = (gate_out != EXPECT[stim]);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_DRIVE;
      ST_DRIVE: begin
        busy       = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy       = 1'b1;
        state_next = (stim == LAST_VEC) ? ST_FINISH : ST_DRIVE;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath: stimulus vector, settle counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim       <= '0;
      settle_cnt <= '0;
      fail_flag  <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            stim       <= '0;
            fail_flag  <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        ST_DRIVE: settle_cnt <= SETTLE_LOAD;
        ST_WAIT: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_flag) begin
              first_fail <= stim;
              fail_flag  <= 1'b1;
            end
          end
          // pass is resolved here so it already accounts for the final vector
          // and is valid alongside done in FINISH.
          if (stim == LAST_VEC) pass <= !mismatch && (err_count == '0);
          else                  stim <= stim + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed testbench for gate_truth_checker: a NAND2-configured instance driven
// by a selectable behavioural gate, and an XOR3-configured instance.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start2 = 1'b0, start3 = 1'b0;
  logic       gate_out2, gate_out3;
  logic [1:0] stim2;
  logic [2:0] stim3;
  logic       busy2, done2, pass2, busy3, done3, pass3;
  logic [2:0] err2;
  logic [3:0] err3;
  logic [1:0] ff2;
  logic [2:0] ff3;

  int vectors = 0;
  int miscompares = 0;
  int gate_mode = 0;  // 0 = NAND2, 1 = AND2, 2 = stuck at 1
  int stim_trace[$];

  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      1:       gate_out2 = stim2[1] & stim2[0];
      2:       gate_out2 = 1'b1;
      default: gate_out2 = ~(stim2[1] & stim2[0]);
    endcase
  end
  assign gate_out3 = ^stim3;

  gate_truth_checker dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_out(gate_out2),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2)
  );

  gate_truth_checker #(.N_IN(3), .EXPECT(8'b1001_0110), .SETTLE(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .gate_out(gate_out3),
    .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3)
  );

  // Pulses start, then counts rising edges until done is seen. A second start
  // pulse is issued at edge count pulse_at (0 = none).
  task automatic do_sweep(input bit use3, input int pulse_at, output int lat, output bit ok);
    int cur;
    ok = 1'b0;
    lat = 0;
    stim_trace.delete();
    @(negedge clk);
    if (use3) start3 = 1'b1; else start2 = 1'b1;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start2 = 1'b0;
      start3 = 1'b0;
      if (pulse_at != 0 && lat == pulse_at) begin
        if (use3) start3 = 1'b1; else start2 = 1'b1;
      end
      cur = use3 ? int'(stim3) : int'(stim2);
      if ((use3 ? busy3 : busy2) &&
          (stim_trace.size() == 0 || stim_trace[stim_trace.size()-1] != cur))
        stim_trace.push_back(cur);
      if (use3 ? done3 : done2) begin
        ok = 1'b1;
        break;
      end
    end
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic check_trace(input string name, input int n);
    vectors++;
    if (stim_trace.size() != n) begin
      miscompares++;
      $display("FAIL %s stim trace length got %0d want %0d", name, stim_trace.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (stim_trace[i] != i) begin
          miscompares++;
          $display("FAIL %s stim step %0d got %0d want %0d", name, i, stim_trace[i], i);
        end
      end
    end
  endtask

  task automatic check_result2(input string name, input int lat, input bit ok,
                               input bit exp_pass, input int exp_err, input int exp_ff);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s done timeout after %0d cycles", name, lat);
      return;
    end
    vectors++;
    if (lat != 17) begin miscompares++; $display("FAIL %s latency got %0d want 17", name, lat); end
    vectors++;
    if (pass2 !== exp_pass) begin miscompares++; $display("FAIL %s pass got %b want %b", name, pass2, exp_pass); end
    vectors++;
    if (err2 !== 3'(exp_err)) begin miscompares++; $display("FAIL %s err_count got %0d want %0d", name, err2, exp_err); end
    vectors++;
    if (ff2 !== 2'(exp_ff)) begin miscompares++; $display("FAIL %s first_fail got %0d want %0d", name, ff2, exp_ff); end
    vectors++;
    if (busy2 !== 1'b0) begin miscompares++; $display("FAIL %s busy during done got %b want 0", name, busy2); end
    // done is a single-cycle pulse; results and stim then hold.
    @(negedge clk);
    vectors++;
    if (done2 !== 1'b0) begin miscompares++; $display("FAIL %s done width got %b want 0", name, done2); end
    repeat (3) @(negedge clk);
    vectors++;
    if ({pass2, err2, ff2, stim2} !== {exp_pass, 3'(exp_err), 2'(exp_ff), 2'b11}) begin
      miscompares++;
      $display("FAIL %s hold got pass=%b err=%0d ff=%0d stim=%0d want pass=%b err=%0d ff=%0d stim=3",
               name, pass2, err2, ff2, stim2, exp_pass, exp_err, exp_ff);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({stim2, busy2, done2, pass2, err2, ff2} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset dut2 got stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d want all 0",
               stim2, busy2, done2, pass2, err2, ff2);
    end
    vectors++;
    if ({stim3, busy3, done3, pass3, err3, ff3} !== 13'b0) begin
      miscompares++;
      $display("FAIL reset dut3 got stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d want all 0",
               stim3, busy3, done3, pass3, err3, ff3);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nand_correct();
    int lat; bit ok;
    gate_mode = 0;
    do_sweep(1'b0, 0, lat, ok);
    check_trace("nand_sweep", 4);
    check_result2("nand_ok", lat, ok, 1'b1, 0, 0);
  endtask

  task automatic test_wrong_gate();
    int lat; bit ok;
    gate_mode = 1;
    do_sweep(1'b0, 0, lat, ok);
    check_result2("and_gate", lat, ok, 1'b0, 4, 0);
  endtask

  task automatic test_stuck_one();
    int lat; bit ok;
    gate_mode = 2;
    do_sweep(1'b0, 0, lat, ok);
    check_result2("stuck1", lat, ok, 1'b0, 1, 3);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int dones = 0;
    int lat; bit ok;
    gate_mode = 1;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (stim2 != 2'd2 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);  // first WAIT cycle of vector 10
    vectors++;
    if (busy2 !== 1'b1 || err2 !== 3'd2) begin
      miscompares++;
      $display("FAIL mid_reset pre got busy=%b err=%0d want busy=1 err=2", busy2, err2);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({stim2, busy2, done2, pass2, err2, ff2} !== 9'b0) begin
      miscompares++;
      $display("FAIL mid_reset async got stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d want all 0",
               stim2, busy2, done2, pass2, err2, ff2);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done2 || busy2) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL mid_reset idle activity got %0d want 0", dones); end
    gate_mode = 0;
    do_sweep(1'b0, 0, lat, ok);
    check_result2("after_reset", lat, ok, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    int extra = 0;
    gate_mode = 2;
    do_sweep(1'b0, 6, lat, ok);  // second pulse lands mid-sweep and must be ignored
    check_result2("busy_start", lat, ok, 1'b0, 1, 3);
    repeat (20) begin
      @(negedge clk);
      if (done2 || busy2) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL busy_start extra activity got %0d want 0", extra); end
    // New sweep: results cleared and pass forced low as soon as it starts.
    gate_mode = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    vectors++;
    if ({busy2, pass2, err2, ff2} !== {1'b1, 1'b0, 3'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL rerun clear got busy=%b pass=%b err=%0d ff=%0d want busy=1 pass=0 err=0 ff=0",
               busy2, pass2, err2, ff2);
    end
    lat = 0;
    ok = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done2) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok || pass2 !== 1'b1 || err2 !== 3'd0) begin
      miscompares++;
      $display("FAIL rerun result got done=%b pass=%b err=%0d want done=1 pass=1 err=0", ok, pass2, err2);
    end
  endtask

  task automatic test_xor3();
    int lat; bit ok;
    do_sweep(1'b1, 0, lat, ok);
    check_trace("xor3_sweep", 8);
    vectors++;
    if (!ok || lat != 25) begin
      miscompares++;
      $display("FAIL xor3 latency got %0d (done=%b) want 25", lat, ok);
    end
    vectors++;
    if ({pass3, err3, ff3} !== {1'b1, 4'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL xor3 result got pass=%b err=%0d ff=%0d want pass=1 err=0 ff=0", pass3, err3, ff3);
    end
  endtask

  initial begin
    test_reset();
    test_nand_correct();
    test_wrong_gate();
    test_stuck_one();
    test_mid_reset();
    test_back_to_back();
    test_xor3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
